// File: rtl/pe_pkg.sv
// pe_pkg: state encoding, config layout and legality helper for the row-stationary PE
package pe_pkg;
    localparam int CFG_W = 15;
    localparam int R_W = 2;
    localparam int S_W = 2;
    localparam int P_W = 3;
    localparam int Q_W = 2;
    localparam int F_W = 5;
    // wide enough for the largest p*R*q the config fields can encode
    localparam int CNT_W = $clog2((1 << P_W) * (1 << R_W) * (1 << Q_W) + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILTER,
        LOAD_IFMAP,
        LOAD_IPSUM,
        COMPUTE,
        WRITE_OPSUM,
        DONE
    } state_t;

    typedef struct packed {
        logic           zero;
        logic [F_W-1:0] f;
        logic [Q_W-1:0] q1;
        logic [P_W-1:0] p1;
        logic [S_W-1:0] s1;
        logic [R_W-1:0] r1;
    } cfg_t;

    function automatic logic cfg_legal(cfg_t c, int fd, int id, int pd, int lanes);
        int r = int'(c.r1) + 1;
        int s = int'(c.s1) + 1;
        int p = int'(c.p1) + 1;
        int q = int'(c.q1) + 1;
        return (p * r * q <= fd) && (r * q <= id) && (p <= pd) && (q <= lanes) && (s <= r);
    endfunction
endpackage

// File: rtl/pe_rs_stride_mac.sv
// pe_mac: signed activation x weight product added to a wrapping psum
module pe_mac #(
    parameter int ACT_W  = 8,
    parameter int WGT_W  = 8,
    parameter int PSUM_W = 32
) (
    input  logic [ACT_W-1:0]  act,
    input  logic [WGT_W-1:0]  wgt,
    input  logic [PSUM_W-1:0] acc,
    output logic [PSUM_W-1:0] sum
);
    logic signed [ACT_W+WGT_W-1:0] prod;

    assign prod = $signed(act) * $signed(wgt);
    assign sum  = acc + PSUM_W'(prod);
endmodule

// File: rtl/pe_rs_stride.sv
// pe_rs_stride: parametrised row-stationary PE with stride, zero-init psums and config checking
module pe_rs_stride
    import pe_pkg::*;
#(
    parameter int ACT_W        = 8,
    parameter int WGT_W        = 8,
    parameter int PSUM_W       = 32,
    parameter int LANES        = 4,
    parameter int IFMAP_DEPTH  = 12,
    parameter int FILTER_DEPTH = 48,
    parameter int PSUM_DEPTH   = 8,
    parameter int ZP_FLIP      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pe_en,
    input  logic [CFG_W-1:0]       cfg,
    input  logic [LANES*ACT_W-1:0] ifmap,
    input  logic                   ifmap_valid,
    output logic                   ifmap_ready,
    input  logic [LANES*WGT_W-1:0] filter,
    input  logic                   filter_valid,
    output logic                   filter_ready,
    input  logic [PSUM_W-1:0]      ipsum,
    input  logic                   ipsum_valid,
    output logic                   ipsum_ready,
    output logic [PSUM_W-1:0]      opsum,
    output logic                   opsum_valid,
    input  logic                   opsum_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);
    localparam int FW = $clog2(FILTER_DEPTH);
    localparam int IW = $clog2(IFMAP_DEPTH);
    localparam int PW = $clog2(PSUM_DEPTH);
    localparam logic [CNT_W-1:0] ONE = 1;
    localparam logic [ACT_W-1:0] FLIP = (ZP_FLIP != 0) ? ACT_W'(1) << (ACT_W - 1) : '0;

    state_t state, state_n;
    cfg_t cfg_q, cin;
    logic [WGT_W-1:0] fspad [FILTER_DEPTH];
    logic [ACT_W-1:0] ispad [IFMAP_DEPTH];
    logic [PSUM_W-1:0] psum [PSUM_DEPTH];
    logic [CNT_W-1:0] r, s, p, q, rq, prq, sq, base;
    logic [CNT_W-1:0] faddr, iaddr, pidx, fcnt, m, k;
    logic [F_W-1:0] col;
    logic [PSUM_W-1:0] mac_sum;
    logic legal, f_last, i_last, p_last, c_last, k_last, more;

    assign cin    = cfg_t'(cfg);
    assign legal  = cfg_legal(cin, FILTER_DEPTH, IFMAP_DEPTH, PSUM_DEPTH, LANES);
    assign r      = CNT_W'(cfg_q.r1) + ONE;
    assign s      = CNT_W'(cfg_q.s1) + ONE;
    assign p      = CNT_W'(cfg_q.p1) + ONE;
    assign q      = CNT_W'(cfg_q.q1) + ONE;
    assign rq     = r * q;
    assign prq    = p * rq;
    assign sq     = s * q;
    assign base   = (r - s) * q;
    assign f_last = faddr + CNT_W'(LANES) >= prq;
    assign i_last = iaddr + q >= rq;
    assign p_last = pidx == p - ONE;
    assign c_last = fcnt == prq - ONE;
    assign k_last = k == rq - ONE;
    assign more   = col != cfg_q.f;

    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign filter_ready = state == LOAD_FILTER;
    assign ifmap_ready  = state == LOAD_IFMAP;
    assign ipsum_ready  = state == LOAD_IPSUM;
    assign opsum_valid  = state == WRITE_OPSUM;
    assign opsum        = opsum_valid ? psum[PW'(pidx)] : '0;

    pe_mac #(.ACT_W(ACT_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W)) u_mac (
        .act(ispad[IW'(k)]),
        .wgt(fspad[FW'(fcnt)]),
        .acc(psum[PW'(m)]),
        .sum(mac_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:        if (pe_en && legal) state_n = LOAD_FILTER;
            LOAD_FILTER: if (filter_valid && f_last) state_n = LOAD_IFMAP;
            LOAD_IFMAP:  if (ifmap_valid && i_last) state_n = cfg_q.zero ? COMPUTE : LOAD_IPSUM;
            LOAD_IPSUM:  if (ipsum_valid && p_last) state_n = COMPUTE;
            COMPUTE:     if (c_last) state_n = WRITE_OPSUM;
            WRITE_OPSUM: if (opsum_ready && p_last) state_n = more ? LOAD_IFMAP : DONE;
            default:     state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q   <= '0;
            cfg_err <= 1'b0;
            faddr   <= '0;
            iaddr   <= '0;
            pidx    <= '0;
            fcnt    <= '0;
            m       <= '0;
            k       <= '0;
            col     <= '0;
            for (int i = 0; i < FILTER_DEPTH; i++) fspad[i] <= '0;
            for (int i = 0; i < IFMAP_DEPTH; i++) ispad[i] <= '0;
            for (int i = 0; i < PSUM_DEPTH; i++) psum[i] <= '0;
        end else begin
            case (state)
                IDLE: if (pe_en) begin
                    cfg_q   <= cin;
                    cfg_err <= !legal;
                    faddr   <= '0;
                    iaddr   <= '0;
                    pidx    <= '0;
                    fcnt    <= '0;
                    m       <= '0;
                    k       <= '0;
                    col     <= '0;
                end
                LOAD_FILTER: if (filter_valid) begin
                    for (int i = 0; i < LANES; i++)
                        if (faddr + CNT_W'(i) < prq)
                            fspad[FW'(faddr + CNT_W'(i))] <= filter[i*WGT_W +: WGT_W];
                    faddr <= faddr + CNT_W'(LANES);
                end
                LOAD_IFMAP: if (ifmap_valid) begin
                    for (int i = 0; i < LANES; i++)
                        if (CNT_W'(i) < q)
                            ispad[IW'(iaddr + CNT_W'(i))] <= ifmap[i*ACT_W +: ACT_W] ^ FLIP;
                    iaddr <= iaddr + q;
                    if (i_last && cfg_q.zero)
                        for (int i = 0; i < PSUM_DEPTH; i++) psum[i] <= '0;
                end
                LOAD_IPSUM: if (ipsum_valid) begin
                    psum[PW'(pidx)] <= ipsum;
                    pidx <= p_last ? '0 : pidx + ONE;
                end
                COMPUTE: begin
                    psum[PW'(m)] <= mac_sum;
                    fcnt <= c_last ? '0 : fcnt + ONE;
                    k    <= (c_last || k_last) ? '0 : k + ONE;
                    m    <= c_last ? '0 : k_last ? m + ONE : m;
                end
                WRITE_OPSUM: if (opsum_ready) begin
                    pidx <= p_last ? '0 : pidx + ONE;
                    // slide the window down by one stride; new rows land at the top
                    if (p_last && more) begin
                        col   <= col + F_W'(1);
                        iaddr <= base;
                        for (int i = 0; i < IFMAP_DEPTH; i++)
                            ispad[i] <= (CNT_W'(i) + sq < rq) ? ispad[IW'(CNT_W'(i) + sq)] : '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_rs_stride.sv
// tb_pe_rs_stride: table-driven directed checks of the row-stationary PE
module tb_pe_rs_stride;
    localparam int TO = 400;

    typedef struct packed {
        logic [14:0]      cfg;
        logic [3:0]       nf, ni, np, no, stall;
        logic [7:0][31:0] fb, ib, pb, ex;
    } vec_t;

    vec_t vecs [6];
    vec_t cur;

    logic clk = 1'b0, rst = 1'b1, pe_en = 1'b0;
    logic [14:0] cfg = '0;
    logic [31:0] ifmap = '0, filter = '0, ipsum = '0;
    logic ifmap_valid = 1'b0, filter_valid = 1'b0, ipsum_valid = 1'b0, opsum_ready = 1'b0;
    logic ifmap_ready, filter_ready, ipsum_ready, opsum_valid, busy, done, cfg_err;
    logic [31:0] opsum;

    int n_checks = 0, n_fail = 0;
    int fr_cnt = 0, ir_cnt = 0, pr_cnt = 0;
    bit okf, oki, okp, oko;

    pe_rs_stride dut (
        .clk(clk), .rst(rst), .pe_en(pe_en), .cfg(cfg),
        .ifmap(ifmap), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .filter(filter), .filter_valid(filter_valid), .filter_ready(filter_ready),
        .ipsum(ipsum), .ipsum_valid(ipsum_valid), .ipsum_ready(ipsum_ready),
        .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        fr_cnt <= fr_cnt + int'(filter_ready);
        ir_cnt <= ir_cnt + int'(ifmap_ready);
        pr_cnt <= pr_cnt + int'(ipsum_ready);
    end

    task check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task do_reset;
        rst = 1'b1; pe_en = 1'b0; cfg = '0;
        filter_valid = 1'b0; ifmap_valid = 1'b0; ipsum_valid = 1'b0; opsum_ready = 1'b0;
        filter = '0; ifmap = '0; ipsum = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task run_vec(input int n);
        int f0, i0, p0;
        cur = vecs[n];
        do_reset();
        f0 = fr_cnt; i0 = ir_cnt; p0 = pr_cnt;
        cfg = cur.cfg; pe_en = 1'b1; opsum_ready = (cur.stall == 4'd0);
        @(posedge clk); #1 pe_en = 1'b0;
        fork
            begin
                for (int b = 0; b < int'(cur.nf); b++) begin
                    filter = cur.fb[b]; filter_valid = 1'b1; okf = 1'b0;
                    for (int t = 0; t < TO && !okf; t++) begin @(negedge clk); okf = filter_ready; @(posedge clk); #1; end
                end
                filter_valid = 1'b0;
            end
            begin
                for (int b = 0; b < int'(cur.ni); b++) begin
                    ifmap = cur.ib[b]; ifmap_valid = 1'b1; oki = 1'b0;
                    for (int t = 0; t < TO && !oki; t++) begin @(negedge clk); oki = ifmap_ready; @(posedge clk); #1; end
                end
                ifmap_valid = 1'b0;
            end
            begin
                for (int b = 0; b < int'(cur.np); b++) begin
                    ipsum = cur.pb[b]; ipsum_valid = 1'b1; okp = 1'b0;
                    for (int t = 0; t < TO && !okp; t++) begin @(negedge clk); okp = ipsum_ready; @(posedge clk); #1; end
                end
                ipsum_valid = 1'b0;
            end
            begin
                for (int j = 0; j < int'(cur.no); j++) begin
                    oko = 1'b0;
                    for (int t = 0; t < TO && !oko; t++) begin @(negedge clk); oko = opsum_valid; end
                    if (!oko) begin
                        check($sformatf("v%0d opsum%0d valid timeout", n, j), 64'd0, 64'd1);
                        break;
                    end
                    if (j == 0)
                        for (int st = 0; st < int'(cur.stall); st++) begin
                            check($sformatf("v%0d stall%0d opsum", n, st), 64'({opsum_valid, opsum}), 64'({1'b1, cur.ex[0]}));
                            @(negedge clk);
                        end
                    opsum_ready = 1'b1;
                    check($sformatf("v%0d opsum%0d", n, j), 64'(opsum), 64'(cur.ex[j]));
                    @(posedge clk); #1;
                end
                check($sformatf("v%0d done pulse", n), 64'(done), 64'd1);
                @(posedge clk); #1;
                check($sformatf("v%0d done/busy after", n), 64'({done, busy}), 64'd0);
            end
        join
        check($sformatf("v%0d filter beats", n), 64'(fr_cnt - f0), 64'(cur.nf));
        check($sformatf("v%0d ifmap beats", n), 64'(ir_cnt - i0), 64'(cur.ni));
        check($sformatf("v%0d ipsum beats", n), 64'(pr_cnt - p0), 64'(cur.np));
    endtask

    initial begin
        foreach (vecs[i]) vecs[i] = '0;
        // basic: R=3 S=1 p=1 q=1 F=0, acts 1,2,3 after MSB flip, ipsum 10
        vecs[0].cfg = 15'h0002; vecs[0].nf = 4'd1; vecs[0].ni = 4'd3; vecs[0].np = 4'd1; vecs[0].no = 4'd1;
        vecs[0].fb[0] = 32'h55010101;
        vecs[0].ib[0] = 32'hAABBCC81; vecs[0].ib[1] = 32'h00000082; vecs[0].ib[2] = 32'h00000083;
        vecs[0].pb[0] = 32'd10; vecs[0].ex[0] = 32'd16;
        // stride 2 over two columns
        vecs[1].cfg = 15'h0206; vecs[1].nf = 4'd1; vecs[1].ni = 4'd5; vecs[1].np = 4'd2; vecs[1].no = 4'd2;
        vecs[1].fb[0] = 32'h00030201;
        vecs[1].ib[0] = 32'h81; vecs[1].ib[1] = 32'h82; vecs[1].ib[2] = 32'h83; vecs[1].ib[3] = 32'h84; vecs[1].ib[4] = 32'h85;
        vecs[1].ex[0] = 32'd14; vecs[1].ex[1] = 32'd26;
        // p=4 with opsum backpressure
        vecs[2].cfg = 15'h0030; vecs[2].nf = 4'd1; vecs[2].ni = 4'd1; vecs[2].np = 4'd4; vecs[2].no = 4'd4; vecs[2].stall = 4'd5;
        vecs[2].fb[0] = 32'h04030201; vecs[2].ib[0] = 32'h00000082;
        vecs[2].ex[0] = 32'd2; vecs[2].ex[1] = 32'd4; vecs[2].ex[2] = 32'd6; vecs[2].ex[3] = 32'd8;
        // zero-init psum, -1 x 127
        vecs[3].cfg = 15'h4000; vecs[3].nf = 4'd1; vecs[3].ni = 4'd1; vecs[3].np = 4'd0; vecs[3].no = 4'd1;
        vecs[3].fb[0] = 32'h000000FF; vecs[3].ib[0] = 32'h000000FF; vecs[3].ex[0] = 32'hFFFFFF81;
        // R=2 q=4 p=2: multi-beat filter load, full-lane ifmap
        vecs[4].cfg = 15'h0191; vecs[4].nf = 4'd4; vecs[4].ni = 4'd2; vecs[4].np = 4'd2; vecs[4].no = 4'd2;
        vecs[4].fb[0] = 32'h01010101; vecs[4].fb[1] = 32'h01010101; vecs[4].fb[2] = 32'hFFFFFFFF; vecs[4].fb[3] = 32'hFFFFFFFF;
        vecs[4].ib[0] = 32'h84838281; vecs[4].ib[1] = 32'h88878685;
        vecs[4].pb[0] = 32'd100; vecs[4].pb[1] = 32'd50; vecs[4].ex[0] = 32'd136; vecs[4].ex[1] = 32'd14;
        // R=2 S=1 q=2 F=1: window shift by q entries
        vecs[5].cfg = 15'h0281; vecs[5].nf = 4'd1; vecs[5].ni = 4'd3; vecs[5].np = 4'd2; vecs[5].no = 4'd2;
        vecs[5].fb[0] = 32'h04030201;
        vecs[5].ib[0] = 32'h11118281; vecs[5].ib[1] = 32'h22228483; vecs[5].ib[2] = 32'h00008685;
        vecs[5].ex[0] = 32'd30; vecs[5].ex[1] = 32'd50;

        // reset held with every input active
        rst = 1'b1; pe_en = 1'b1; cfg = vecs[0].cfg;
        filter_valid = 1'b1; ifmap_valid = 1'b1; ipsum_valid = 1'b1; opsum_ready = 1'b1;
        filter = '1; ifmap = '1; ipsum = '1;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("reset cycle %0d", c),
                  64'({opsum, opsum_valid, filter_ready, ifmap_ready, ipsum_ready, busy, done, cfg_err}), 64'd0);
        end

        for (int n = 0; n < 6; n++) run_vec(n);

        // illegal config, then recovery, pe_en ignored while busy, async abort
        do_reset();
        cfg = 15'h01F3; pe_en = 1'b1; @(posedge clk); #1 pe_en = 1'b0;
        check("illegal cfg_err", 64'(cfg_err), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("illegal idle %0d", c),
                  64'({busy, filter_ready, ifmap_ready, ipsum_ready, opsum_valid}), 64'd0);
        end
        cfg = 15'h0004; pe_en = 1'b1; @(posedge clk); #1 pe_en = 1'b0;
        check("S>R cfg_err", 64'({cfg_err, busy}), 64'b10);
        cfg = vecs[0].cfg; pe_en = 1'b1; @(posedge clk); #1 pe_en = 1'b0;
        check("legal clears cfg_err", 64'({cfg_err, busy, filter_ready}), 64'b011);
        cfg = 15'h01F3; pe_en = 1'b1; @(posedge clk); #1 pe_en = 1'b0;
        check("pe_en ignored when busy", 64'({cfg_err, busy, filter_ready}), 64'b011);
        rst = 1'b1; #1;
        check("async abort", 64'({busy, filter_ready, cfg_err}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_rs_stride.md
Name: pe_rs_stride

Overview:
Parametrised row-stationary processing element, the next-generation PE for the CNN accelerator array. It has generic activation, weight and psum widths, packing factor and scratchpad depths. It adds convolution stride, optional zero-initialised psums (no ipsum fetch) and configuration checking. It sits in the PE array between the GLB-fed ifmap, filter and ipsum streams and the opsum return path, all valid/ready handshaked.

Parameters:
ACT_W, 8, activation element width
WGT_W, 8, weight element width
PSUM_W, 32, psum/opsum width; also the ipsum and opsum bus width
LANES, 4, elements packed per ifmap/filter beat (bus width LANES*ACT_W, LANES*WGT_W)
IFMAP_DEPTH, 12, ifmap spad entries
FILTER_DEPTH, 48, filter spad entries
PSUM_DEPTH, 8, psum spad entries
ZP_FLIP, 1, 1 = XOR activation MSB on load (uint to int)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pe_en  in  1  start; sampled only in IDLE
cfg  in  15  [1:0]R-1, [3:2]S-1, [6:4]p-1, [8:7]q-1, [13:9]F (columns-1), [14]psum_init_zero
ifmap  in  LANES*ACT_W  packed activations, lane0 = LSBs
ifmap_valid / ifmap_ready  in / out  1  ifmap handshake
filter  in  LANES*WGT_W  packed weights, lane0 = LSBs
filter_valid / filter_ready  in / out  1  filter handshake
ipsum  in  PSUM_W  input psum
ipsum_valid / ipsum_ready  in / out  1  ipsum handshake
opsum  out  PSUM_W  output psum
opsum_valid / opsum_ready  out / in  1  opsum handshake
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last column's last opsum
cfg_err  out  1  sticky illegal-config flag

Behaviour:
- Reset values: all outputs 0; spads, counters and cfg register cleared; state IDLE.
- IDLE:
  - pe_en=1 captures cfg and clears cfg_err.
  - Legal cfg means p*R*q<=FILTER_DEPTH, R*q<=IFMAP_DEPTH, p<=PSUM_DEPTH, q<=LANES and S<=R.
  - Legal cfg goes to LOAD_FILTER. Illegal cfg sets cfg_err=1 and stays IDLE.
  - pe_en is ignored outside IDLE.
- LOAD_FILTER:
  - filter_ready=1. Each accepted beat writes LANES elements at consecutive addresses.
  - ceil(p*R*q/LANES) beats in total. Surplus lanes of the final beat are discarded.
  - Layout: addr = m*R*q + r*q + c.
  - Then goes to LOAD_IFMAP.
- LOAD_IFMAP:
  - ifmap_ready=1. Each beat supplies q elements (lanes 0..q-1); lanes >= q are ignored.
  - First column: R beats fill addr 0..R*q-1.
  - Later columns: the window was already shifted down by S*q (vacated entries zeroed), so S beats fill the top S*q entries.
  - Then goes to LOAD_IPSUM, or to COMPUTE with psums zeroed if psum_init_zero=1.
- LOAD_IPSUM: ipsum_ready=1; p beats written to psum[0..p-1] in order, then COMPUTE.
- COMPUTE:
  - One MAC per cycle, p*R*q cycles.
  - Index m = 0..p-1 (outer), k = 0..R*q-1 (inner): psum[m] += filter[m*R*q+k] * ifmap[k].
  - Operands are signed and sign-extended to PSUM_W; the sum wraps modulo 2^PSUM_W.
  - No handshake ports are ready during COMPUTE.
- WRITE_OPSUM:
  - opsum_valid=1 and opsum=psum[idx], idx = 0..p-1, advancing on valid&&ready.
  - opsum is stable while stalled.
  - After the p-th accept:
    - If columns remain: shift the ifmap window by S*q and go to LOAD_IFMAP.
    - Else: go to DONE.
- DONE: done=1 for one cycle, then IDLE. The filter spad is retained until the next pe_en.
- Rules:
  - ready is registered-state decoded; data is captured only on valid&&ready in the owning state.
  - Asserting rst mid-operation aborts immediately and returns to reset values.
  - The column counter counts 0..F. Column F+1 never occurs.

Decomposition:
- Package pe_pkg: state enum, cfg field offsets and widths, cfg struct, clog2-derived index widths.
- One sub-module, pe_mac: signed ACT_W x WGT_W multiply plus PSUM_W accumulate, combinational.

Test Plan:
- Reset with stimulus active -> all outputs 0, busy=0, no ready asserted for 5 cycles.
- Basic accumulate:
  - Config: R=3, S=1, p=1, q=1, F=0; filters 1,1,1; ifmap 0x81, 0x82, 0x83 (ZP_FLIP gives 1, 2, 3); ipsum 10.
  - Expected: opsum=16, then done pulse; exactly 1 filter beat, 3 ifmap beats, 1 ipsum beat.
- Stride:
  - Config: R=3, S=2, p=1, q=1, F=1; filters 1,2,3.
  - Column 0: ifmap 1,2,3, ipsum 0 -> opsum 14. Column 1: 2 beats 4,5 -> opsum 3*1+4*2+5*3 = 26.
- Backpressure with p=4:
  - Filters for m give weight m+1, R=1, q=1; ifmap 2; ipsums 0.
  - Hold opsum_ready low 5 cycles -> opsum stays 2 while stalled; sequence is 2, 4, 6, 8.
- psum_init_zero=1 -> ipsum_ready never asserts; opsum equals pure convolution. Negative weight 0xFF x act 0x7F gives -127 (0xFFFFFF81).
- Illegal cfg p=8, R=4, q=4 (128>48) -> cfg_err=1, busy=0, no ready. Next legal pe_en -> cfg_err cleared.
